spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target.sv | 147 ++++++++++++++
 tb/tb_spi_target.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target with a one-deep TX holding register and a one-deep RX buffer.
// SCK, CS and MOSI are synchronised into clk; all protocol work happens on detected edges.
module spi_target #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic [2:0]        status_o,
    input  logic              status_clr_i,
    output logic              irq_o
);
    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state;
    logic [SYNC_STAGES:0]   sck_sr;
    logic [SYNC_STAGES:0]   cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   rx_shift;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_full;
    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;
    logic [2:0]          status;

    logic                sck_rise, sck_fall, cs_fall, cs_rise, mosi_sync;
    logic                tx_load, tx_reload, rx_read;
    logic [DATA_W-1:0]   rx_next;

    // Top bit of each SCK/CS chain is the previous synchronised sample, used for edge detection.
    assign sck_rise  =  sck_sr[SYNC_STAGES-1] & ~sck_sr[SYNC_STAGES];
    assign sck_fall  = ~sck_sr[SYNC_STAGES-1] &  sck_sr[SYNC_STAGES];
    assign cs_fall   = ~cs_sr[SYNC_STAGES-1]  &  cs_sr[SYNC_STAGES];
    assign cs_rise   =  cs_sr[SYNC_STAGES-1]  & ~cs_sr[SYNC_STAGES];
    assign mosi_sync =  mosi_sr[SYNC_STAGES-1];

    assign rx_next   = {rx_shift[DATA_W-2:0], mosi_sync};
    assign tx_load   = tx_valid_i & ~hold_full;
    assign rx_read   = rx_valid & rx_ready_i;
    // Frame start, or a falling edge that follows a completed frame, pulls the next TX byte.
    assign tx_reload = (state == IDLE) ? cs_fall : (~cs_rise & sck_fall & (bit_cnt == '0));

    assign spi_miso_o    = tx_shift[DATA_W-1];
    assign spi_miso_oe_o = (state == ACTIVE);
    assign tx_ready_o    = ~hold_full;
    assign rx_data_o     = rx_data;
    assign rx_valid_o    = rx_valid;
    assign status_o      = status;
    assign irq_o         = rx_valid | (|status);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sck_sr    <= '0;
            cs_sr     <= '1;
            mosi_sr   <= '0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            status    <= '0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-1:0], spi_clk_i};
            cs_sr   <= {cs_sr[SYNC_STAGES-1:0], spi_cs_i};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2+1-1:0], spi_mosi_i};

            // A load needs an empty register and a reload only empties a full one, so they never collide.
            if (tx_load) begin
                hold_data <= tx_data_i;
                hold_full <= 1'b1;
            end else if (tx_reload && hold_full) begin
                hold_full <= 1'b0;
            end

            if (rx_read) begin
                rx_valid <= 1'b0;
            end

            // Clear first so that any flag set below in the same cycle takes precedence.
            if (status_clr_i) begin
                status <= '0;
            end

            if (tx_reload) begin
                tx_shift <= hold_full ? hold_data : '0;
                if (!hold_full) begin
                    status[1] <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                        if (bit_cnt != '0) begin
                            status[0] <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (!rx_valid || rx_read) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end else begin
                                status[2] <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall && bit_cnt != '0) begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed scenarios plus randomized sessions scored against a byte-level model.
`timescale 1ns/1ps
module tb_spi_target;
    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck, spi_cs, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [2:0] status;
    logic       status_clr, irq;

    int checks   = 0;
    int failures = 0;

    // Model state: one-byte holding register, one-byte RX buffer, sticky flags.
    logic       m_hold_full;
    logic [7:0] m_hold;
    logic       m_rx_full;
    logic [7:0] m_rx;
    logic [2:0] m_status;

    always #5 clk = ~clk;

    spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_clk_i    (spi_sck),
        .spi_cs_i     (spi_cs),
        .spi_mosi_i   (spi_mosi),
        .spi_miso_o   (spi_miso),
        .spi_miso_oe_o(spi_miso_oe),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .status_o     (status),
        .status_clr_i (status_clr),
        .irq_o        (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hold_full = 1'b0;
        m_hold      = '0;
        m_rx_full   = 1'b0;
        m_rx        = '0;
        m_status    = '0;
    endtask

    task automatic take_tx(output logic [7:0] b);
        if (m_hold_full) begin
            b           = m_hold;
            m_hold_full = 1'b0;
        end else begin
            b           = '0;
            m_status[1] = 1'b1;
        end
    endtask

    task automatic complete_frame(input logic [7:0] b);
        if (!m_rx_full) begin
            m_rx_full = 1'b1;
            m_rx      = b;
        end else begin
            m_status[2] = 1'b1;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        check_eq("tx_ready", tx_ready, !m_hold_full);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        if (!m_hold_full) begin
            m_hold_full = 1'b1;
            m_hold      = b;
        end
    endtask

    task automatic read_rx();
        check_eq("rx_valid_pre_read", rx_valid, m_rx_full);
        if (m_rx_full) check_eq("rx_data", rx_data, m_rx);
        rx_ready = 1'b1;
        tick();
        rx_ready  = 1'b0;
        m_rx_full = 1'b0;
        check_eq("rx_valid_post_read", rx_valid, 0);
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        m_status   = '0;
        check_eq("status_cleared", status, 0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_oe"}, spi_miso_oe, 0);
        check_eq({tag, "_miso"}, spi_miso, 0);
        check_eq({tag, "_rx_valid"}, rx_valid, m_rx_full);
        if (m_rx_full) check_eq({tag, "_rx_data"}, rx_data, m_rx);
        check_eq({tag, "_status"}, status, m_status);
        check_eq({tag, "_irq"}, irq, m_rx_full | (|m_status));
        check_eq({tag, "_tx_ready"}, tx_ready, !m_hold_full);
    endtask

    // One CS assertion carrying nbits MSB-first bits of word; SCK is left high when CS rises.
    task automatic run_session(input int nbits, input logic [15:0] word,
                               input int refill_at, input logic [7:0] refill_byte);
        logic [7:0] tx_bytes [2];
        logic [7:0] rx_acc;
        logic       mbit;
        rx_acc      = '0;
        tx_bytes[1] = '0;
        spi_cs      = 1'b0;
        repeat (6) tick();
        take_tx(tx_bytes[0]);
        check_eq("oe_active", spi_miso_oe, 1);
        for (int b = 0; b < nbits; b++) begin
            mbit     = word[15 - b];
            spi_sck  = 1'b0;
            spi_mosi = mbit;
            repeat (4) tick();
            if (b == 8) take_tx(tx_bytes[1]);
            if (b == refill_at) push_tx(refill_byte);
            check_eq("miso_bit", spi_miso, tx_bytes[b / 8][7 - (b % 8)]);
            spi_sck = 1'b1;
            repeat (4) tick();
            rx_acc = {rx_acc[6:0], mbit};
            if (b % 8 == 7) begin
                complete_frame(rx_acc);
                check_eq("rx_valid_frame", rx_valid, m_rx_full);
            end
        end
        spi_cs = 1'b1;
        repeat (6) tick();
        if (nbits % 8 != 0) m_status[0] = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) tick();
        check_idle("session");
    endtask

    initial begin
        rst        = 1'b1;
        spi_sck    = 1'b0;
        spi_cs     = 1'b1;
        spi_mosi   = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        status_clr = 1'b0;
        model_reset();
        repeat (3) tick();
        check_eq("rst_rx_data", rx_data, 0);
        check_idle("rst");
        rst = 1'b0;
        repeat (2) tick();

        // Preloaded 0xA5 out, 0x3C in.
        push_tx(8'hA5);
        run_session(8, 16'h3C00, -1, 8'h00);
        check_eq("a5_irq", irq, 1);
        read_rx();

        // No preload: zeros out, underrun flagged, then cleared.
        run_session(8, 16'h9900, -1, 8'h00);
        check_eq("underrun_set", status[1], 1);
        clear_status();
        read_rx();

        // Two frames without reading: first byte kept, overrun flagged.
        run_session(8, 16'h1100, -1, 8'h00);
        run_session(8, 16'h2200, -1, 8'h00);
        check_eq("overrun_set", status[2], 1);
        check_eq("overrun_kept", rx_data, 8'h11);
        read_rx();
        clear_status();

        // Partial frame aborted by CS, then a clean frame.
        run_session(5, 16'hA800, -1, 8'h00);
        check_eq("frame_err_set", status[0], 1);
        check_eq("frame_err_no_rx", rx_valid, 0);
        clear_status();
        push_tx(8'h0F);
        run_session(8, 16'h7E00, -1, 8'h00);
        check_eq("after_err_rx", rx_data, 8'h7E);
        read_rx();

        // Two frames in one session with a refill during the first.
        clear_status();
        push_tx(8'h5A);
        run_session(16, 16'h1234, 3, 8'hC3);
        check_eq("refill_no_underrun", status[1], 0);
        read_rx();
        clear_status();

        // Reset after four bits of a frame.
        push_tx(8'hF0);
        spi_cs = 1'b0;
        repeat (6) tick();
        for (int b = 0; b < 4; b++) begin
            spi_sck  = 1'b0;
            spi_mosi = b[0];
            repeat (4) tick();
            spi_sck = 1'b1;
            repeat (4) tick();
        end
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        check_eq("midrst_rx_data", rx_data, 0);
        check_idle("midrst");
        repeat (4) tick();
        check_idle("midrst_settled");
        push_tx(8'h81);
        run_session(8, 16'h9600, -1, 8'h00);
        check_eq("post_rst_rx", rx_data, 8'h96);
        read_rx();

        // Randomized sessions against the model.
        for (int n = 0; n < 12; n++) begin
            int         nb;
            int         refill;
            logic [15:0] w;
            case ($urandom_range(0, 2))
                0:       nb = 8;
                1:       nb = 16;
                default: nb = $urandom_range(1, 15);
            endcase
            refill = (nb > 8 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : -1;
            w      = 16'($urandom);
            if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
            if ($urandom_range(0, 1) == 1) read_rx();
            if ($urandom_range(0, 3) == 0) clear_status();
            run_session(nb, w, refill, 8'($urandom));
        end
        read_rx();
        clear_status();
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
